wb_sel_decoder: RTL and testbench
=================================

# wb_sel_decoder

Registered writeback stage for the single-cycle RISC-V core, the decode-side counterpart of the writeback-select encoding. It takes the 3-bit writeback-select code produced upstream, decodes it to a one-hot source select, and muxes ALU result, load data, PC+4, PC+imm or immediate onto the register-file write port. Load writebacks wait for a possibly late `load_valid` from data memory under a bounded timeout. A valid/ready handshake stalls the upstream stage while a load is outstanding.

## Interface
- `XLEN`, 32, datapath width.
- `LOAD_TIMEOUT`, 15, max WAIT_LOAD cycles for `load_valid`; must be ≥1.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  upstream writeback request valid.
- `in_ready`  out  1  block can accept a request.
- `wb_sel`  in  3  source code: 000 ALU, 001 load, 010 PC+4, 011 PC+imm, 100 imm, 101–111 illegal.
- `reg_write`  in  1  instruction writes `rd`.
- `rd`  in  5  destination register.
- `alu_result`, `pc_plus4`, `pc_plus_imm`, `imm`  in  XLEN each  candidate sources.
- `load_valid`  in  1  data-memory read data valid.
- `load_data`  in  XLEN  data-memory read data.
- `rf_we`  out  1  register-file write strobe, one-cycle pulse.
- `rf_waddr`  out  5  write address.
- `rf_wdata`  out  XLEN  write data.
- `src_onehot`  out  5  registered decoded source; bit0 ALU … bit4 imm.
- `load_timeout`  out  1  one-cycle pulse, load abandoned.
- `illegal_sel`  out  1  one-cycle pulse; exists only with `WB_ILLEGAL_TRAP_EN`.

## Operation
- FSM states: IDLE, WAIT_LOAD.
- `in_ready` = 1 in IDLE, 0 in WAIT_LOAD.
- Accept = `in_valid & in_ready`. On accept:
  - `src_onehot` updates from `wb_sel`.
  - `src_onehot` holds until the next accept.
- IDLE, accept, non-load code:
  - Register `rf_wdata` = selected source and `rf_waddr` = `rd`.
  - Register `rf_we` = `reg_write & (rd != 0)`.
- IDLE, accept, code 001, `load_valid`=1 in the same cycle: complete as non-load, using `load_data`.
- IDLE, accept, code 001, `load_valid`=0:
  - Capture `rd` and `reg_write`.
  - Clear the counter and enter WAIT_LOAD.
- WAIT_LOAD, `load_valid`=1:
  - Write `load_data` to the captured `rd`, gated as above.
  - Return to IDLE.
- WAIT_LOAD, `load_valid`=0:
  - Counter increments.
  - When the counter == `LOAD_TIMEOUT-1`: pulse `load_timeout`, no write, return to IDLE.
- Simultaneous `load_valid` on the final allowed cycle: the write wins, no timeout.
- `load_valid` in IDLE with no load accepted is ignored.
- Counter width is `$clog2(LOAD_TIMEOUT+1)`; it never wraps.
- Reset:
  - IDLE, counter 0.
  - `rf_we`, `rf_waddr`, `rf_wdata`, `src_onehot`, `load_timeout`, `illegal_sel` all 0.
  - `in_ready` is 1 in the first cycle after reset.
- `rst` during WAIT_LOAD aborts the pending load with no write and no timeout pulse.

## Timing
- Non-load accepted at cycle N: `rf_we`/`rf_waddr`/`rf_wdata` valid at N+1, for one cycle.
- Load accepted at N with `load_valid` at M ≥ N:
  - Write visible at M+1.
  - `in_ready` low N+1..M and high again at M+1 (M > N case).
- Timeout: accept at N, no `load_valid` → `load_timeout` at N+LOAD_TIMEOUT+1, `in_ready` high in the same cycle.
- No combinational path from inputs to `rf_*` outputs; `in_ready` depends only on state.

## Configuration
- `WB_ILLEGAL_TRAP_EN` defined:
  - Codes 101–111 on accept pulse `illegal_sel` at N+1.
  - `rf_we` = 0 and `src_onehot` = 00000.
- Not defined:
  - Codes 101–111 decode as ALU (`src_onehot` = 00001), matching the encoder default.
  - `illegal_sel` port absent.

## Structure
- Package `wb_pkg`:
  - `WB_SEL_ALU`/`LOAD`/`PC4`/`PCIMM`/`IMM` 3-bit constants.
  - One-hot bit-index constants.
  - FSM state enum.
- Sub-module `wb_sel_onehot_dec`: combinational 3→5 decoder with illegal flag; instantiated once.

## Test plan
- Reset, then `wb_sel`=000, `rd`=5, `alu_result`=0x1234 accepted at N → at N+1 `rf_we`=1, `rf_waddr`=5, `rf_wdata`=0x1234, `src_onehot`=00001.
- `wb_sel`=001 with `load_valid`=1 and `load_data`=0xCAFE in the same cycle → write 0xCAFE at N+1, `in_ready` stays 1.
- `wb_sel`=001, `load_valid` 3 cycles later with data 0xBEEF → `in_ready`=0 for 3 cycles, then write 0xBEEF; a new request offered during the stall is not accepted.
- `LOAD_TIMEOUT`=4, load never returns → `load_timeout` pulses at N+5, `rf_we` stays 0; then `load_valid` in IDLE is ignored.
- `rd`=0 with `wb_sel`=010 → `rf_we`=0, `src_onehot`=00100; `rst` asserted mid WAIT_LOAD → no write, all outputs 0.
- `wb_sel`=110:
  - With the macro: `illegal_sel`=1 and `rf_we`=0.
  - Without: writes `alu_result`.

Source files
------------

// File: rtl/wb_sel_decoder_pkg.sv
// wb_pkg: writeback-select encodings, one-hot source bit positions and the
// FSM state type shared by the writeback-select decoder slice.
package wb_pkg;

    // 3-bit writeback-select codes produced by the upstream encoder
    localparam logic [2:0] WB_SEL_ALU   = 3'b000;
    localparam logic [2:0] WB_SEL_LOAD  = 3'b001;
    localparam logic [2:0] WB_SEL_PC4   = 3'b010;
    localparam logic [2:0] WB_SEL_PCIMM = 3'b011;
    localparam logic [2:0] WB_SEL_IMM   = 3'b100;

    // Bit positions inside the 5-bit one-hot source select
    localparam int SRC_W         = 5;
    localparam int SRC_ALU_BIT   = 0;
    localparam int SRC_LOAD_BIT  = 1;
    localparam int SRC_PC4_BIT   = 2;
    localparam int SRC_PCIMM_BIT = 3;
    localparam int SRC_IMM_BIT   = 4;

    // One-hot value an illegal code falls back to when trapping is disabled
    localparam logic [SRC_W-1:0] SRC_ALU_OH = 5'b00001;

    typedef enum logic [0:0] {
        ST_IDLE      = 1'b0,
        ST_WAIT_LOAD = 1'b1
    } wb_state_e;

endpackage

// File: rtl/wb_sel_decoder_if.sv
// Writeback-stage bus: upstream request/handshake, candidate sources,
// data-memory load return and register-file write port.
// Optional: WB_ILLEGAL_TRAP_EN adds the illegal_sel pulse.
interface wb_sel_decoder_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      wb_sel;
    logic            reg_write;
    logic [4:0]      rd;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] pc_plus_imm;
    logic [XLEN-1:0] imm;
    logic            load_valid;
    logic [XLEN-1:0] load_data;
    logic            rf_we;
    logic [4:0]      rf_waddr;
    logic [XLEN-1:0] rf_wdata;
    logic [4:0]      src_onehot;
    logic            load_timeout;
`ifdef WB_ILLEGAL_TRAP_EN
    logic            illegal_sel;
`endif

    modport master (
        output in_valid, wb_sel, reg_write, rd,
        output alu_result, pc_plus4, pc_plus_imm, imm,
        output load_valid, load_data,
        input  in_ready, rf_we, rf_waddr, rf_wdata, src_onehot,
        input  load_timeout
`ifdef WB_ILLEGAL_TRAP_EN
        , input illegal_sel
`endif
    );

    modport slave (
        input  in_valid, wb_sel, reg_write, rd,
        input  alu_result, pc_plus4, pc_plus_imm, imm,
        input  load_valid, load_data,
        output in_ready, rf_we, rf_waddr, rf_wdata, src_onehot,
        output load_timeout
`ifdef WB_ILLEGAL_TRAP_EN
        , output illegal_sel
`endif
    );

endinterface

// File: rtl/wb_sel_decoder_onehot_dec.sv
// wb_sel_onehot_dec: combinational 3-to-5 writeback-select decoder.
// Illegal codes (101-111) yield an all-zero one-hot and raise illegal.
module wb_sel_onehot_dec
    import wb_pkg::*;
(
    input  logic [2:0]       sel,
    output logic [SRC_W-1:0] onehot,
    output logic             illegal
);

    // Map each legal code to its source bit; everything else is flagged
    always_comb begin
        onehot  = 5'b00000;
        illegal = 1'b0;
        case (sel)
            WB_SEL_ALU:   onehot[SRC_ALU_BIT]   = 1'b1;
            WB_SEL_LOAD:  onehot[SRC_LOAD_BIT]  = 1'b1;
            WB_SEL_PC4:   onehot[SRC_PC4_BIT]   = 1'b1;
            WB_SEL_PCIMM: onehot[SRC_PCIMM_BIT] = 1'b1;
            WB_SEL_IMM:   onehot[SRC_IMM_BIT]   = 1'b1;
            default:      illegal               = 1'b1;
        endcase
    end

endmodule

// File: rtl/wb_sel_decoder.sv
// wb_sel_decoder: registered writeback stage. Decodes wb_sel, muxes the
// selected source onto the register-file write port and waits (bounded by
// LOAD_TIMEOUT cycles) for late load data, stalling upstream meanwhile.
// Optional: define WB_ILLEGAL_TRAP_EN to trap codes 101-111 via illegal_sel
// instead of treating them as ALU writebacks.
module wb_sel_decoder
    import wb_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int LOAD_TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            rst,
    wb_sel_decoder_if.slave bus
);

    localparam int               CNT_W    = $clog2(LOAD_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOAD_TIMEOUT - 1);

    wb_state_e        state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [4:0]       pend_rd_r, pend_rd_s;
    logic             pend_we_r, pend_we_s;
    logic             rf_we_r, rf_we_s;
    logic [4:0]       rf_waddr_r, rf_waddr_s;
    logic [XLEN-1:0]  rf_wdata_r, rf_wdata_s;
    logic [SRC_W-1:0] src_oh_r, src_oh_s;
    logic             tmo_r, tmo_s;

    logic [SRC_W-1:0] dec_oh_s;
    logic             dec_ill_s;
    logic [SRC_W-1:0] oh_eff_s;
    logic             trap_s;
    logic             accept_s;
    logic [XLEN-1:0]  sel_data_s;

    wb_sel_onehot_dec u_dec (
        .sel     (bus.wb_sel),
        .onehot  (dec_oh_s),
        .illegal (dec_ill_s)
    );

`ifdef WB_ILLEGAL_TRAP_EN
    logic ill_r;

    assign trap_s   = dec_ill_s;
    assign oh_eff_s = dec_oh_s;

    // Illegal-select pulse, one cycle after the offending accept
    always_ff @(posedge clk) begin
        if (rst) begin
            ill_r <= 1'b0;
        end else begin
            ill_r <= accept_s & trap_s;
        end
    end

    assign bus.illegal_sel = ill_r;
`else
    // Illegal codes fall back to ALU, matching the encoder's default arm
    assign trap_s   = 1'b0;
    assign oh_eff_s = dec_ill_s ? SRC_ALU_OH : dec_oh_s;
`endif

    // Upstream may only hand over a request while no load is outstanding
    assign bus.in_ready = (state_r == ST_IDLE);
    assign accept_s     = bus.in_valid & bus.in_ready;

    // AND-OR mux: at most one one-hot bit is set
    assign sel_data_s = ({XLEN{oh_eff_s[SRC_ALU_BIT]}}   & bus.alu_result)
                      | ({XLEN{oh_eff_s[SRC_LOAD_BIT]}}  & bus.load_data)
                      | ({XLEN{oh_eff_s[SRC_PC4_BIT]}}   & bus.pc_plus4)
                      | ({XLEN{oh_eff_s[SRC_PCIMM_BIT]}} & bus.pc_plus_imm)
                      | ({XLEN{oh_eff_s[SRC_IMM_BIT]}}   & bus.imm);

    // Next-state, load-wait counter and next-output computation
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        pend_rd_s  = pend_rd_r;
        pend_we_s  = pend_we_r;
        rf_we_s    = 1'b0;
        rf_waddr_s = rf_waddr_r;
        rf_wdata_s = rf_wdata_r;
        src_oh_s   = src_oh_r;
        tmo_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    src_oh_s = oh_eff_s;
                    if (oh_eff_s[SRC_LOAD_BIT] && !bus.load_valid) begin
                        // Load data not back yet: remember target and wait
                        pend_rd_s = bus.rd;
                        pend_we_s = bus.reg_write;
                        cnt_s     = '0;
                        state_s   = ST_WAIT_LOAD;
                    end else begin
                        rf_waddr_s = bus.rd;
                        rf_wdata_s = sel_data_s;
                        rf_we_s    = bus.reg_write & (bus.rd != 5'd0) & ~trap_s;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT_LOAD: begin
                if (bus.load_valid) begin
                    // Data arriving on the last allowed cycle still wins
                    rf_waddr_s = pend_rd_r;
                    rf_wdata_s = bus.load_data;
                    rf_we_s    = pend_we_r & (pend_rd_r != 5'd0);
                    state_s    = ST_IDLE;
                end else if (cnt_r == CNT_LAST) begin
                    tmo_s   = 1'b1;
                    state_s = ST_IDLE;
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = '0;
            end
        endcase
    end

    // State and output registers; reset also abandons any pending load
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            cnt_r      <= '0;
            pend_rd_r  <= 5'd0;
            pend_we_r  <= 1'b0;
            rf_we_r    <= 1'b0;
            rf_waddr_r <= 5'd0;
            rf_wdata_r <= '0;
            src_oh_r   <= 5'b00000;
            tmo_r      <= 1'b0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            pend_rd_r  <= pend_rd_s;
            pend_we_r  <= pend_we_s;
            rf_we_r    <= rf_we_s;
            rf_waddr_r <= rf_waddr_s;
            rf_wdata_r <= rf_wdata_s;
            src_oh_r   <= src_oh_s;
            tmo_r      <= tmo_s;
        end
    end

    assign bus.rf_we        = rf_we_r;
    assign bus.rf_waddr     = rf_waddr_r;
    assign bus.rf_wdata     = rf_wdata_r;
    assign bus.src_onehot   = src_oh_r;
    assign bus.load_timeout = tmo_r;

endmodule

// File: tb/tb_wb_sel_decoder.sv
// Testbench for wb_sel_decoder: directed vectors, expected events pushed
// into a scoreboard queue, checked by an independent output monitor.
module tb_wb_sel_decoder;

    localparam int LT = 4;

    logic clk;
    logic rst;
    int   cyc;
    int   n_tests;
    int   n_fail;

    wb_sel_decoder_if #(.XLEN(32)) bus ();

    wb_sel_decoder #(.XLEN(32), .LOAD_TIMEOUT(LT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    logic ill_obs;
`ifdef WB_ILLEGAL_TRAP_EN
    assign ill_obs = bus.illegal_sel;
`else
    assign ill_obs = 1'b0;
`endif

    // flags = {rf_we, load_timeout, illegal_sel}
    typedef struct {
        logic [2:0]  flags;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [4:0]  oh;
        int          cyc;
    } exp_t;

    exp_t sb_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input logic [2:0] flags, input logic [4:0] addr,
                        input logic [31:0] data, input logic [4:0] oh, input int c);
        exp_t e;
        e.flags = flags;
        e.addr  = addr;
        e.data  = data;
        e.oh    = oh;
        e.cyc   = c;
        sb_q.push_back(e);
    endtask

    // Monitor: every presented event is popped and compared
    always @(negedge clk) begin : monitor
        exp_t       e;
        logic [2:0] obs;
        logic       ok;
        if (!rst && (bus.rf_we || bus.load_timeout || ill_obs)) begin
            obs = {bus.rf_we, bus.load_timeout, ill_obs};
            n_tests++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_event: flags=%b addr=%0d data=%h cycle=%0d, nothing expected",
                         obs, bus.rf_waddr, bus.rf_wdata, cyc);
            end else begin
                e  = sb_q.pop_front();
                ok = (obs == e.flags) && (bus.src_onehot == e.oh) && (cyc == e.cyc);
                if (e.flags[2])
                    ok = ok && (bus.rf_waddr == e.addr) && (bus.rf_wdata == e.data);
                if (!ok) begin
                    n_fail++;
                    $display("FAIL event: got flags=%b addr=%0d data=%h oh=%b cyc=%0d expected flags=%b addr=%0d data=%h oh=%b cyc=%0d",
                             obs, bus.rf_waddr, bus.rf_wdata, bus.src_onehot, cyc,
                             e.flags, e.addr, e.data, e.oh, e.cyc);
                end
            end
        end
    end

    // Non-load directed vectors with hand-computed results
    logic [2:0]  v_sel [6] = '{3'b000, 3'b011, 3'b100, 3'b010, 3'b010, 3'b010};
    logic [4:0]  v_rd  [6] = '{5'd5, 5'd12, 5'd13, 5'd0, 5'd6, 5'd6};
    logic        v_rw  [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic        v_we  [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [31:0] v_dat [6] = '{32'h0000_1234, 32'h0000_2000, 32'h0000_0055,
                               32'h0000_0104, 32'h0000_0104, 32'h0000_0104};
    logic [4:0]  v_oh  [6] = '{5'b00001, 5'b01000, 5'b10000, 5'b00100, 5'b00100, 5'b00100};

    initial begin
        cyc             = 0;
        n_tests         = 0;
        n_fail          = 0;
        rst             = 1'b1;
        bus.in_valid    = 1'b0;
        bus.wb_sel      = 3'b000;
        bus.reg_write   = 1'b0;
        bus.rd          = 5'd0;
        bus.alu_result  = 32'h0000_1234;
        bus.pc_plus4    = 32'h0000_0104;
        bus.pc_plus_imm = 32'h0000_2000;
        bus.imm         = 32'h0000_0055;
        bus.load_valid  = 1'b0;
        bus.load_data   = 32'h0000_0000;

        // Reset state
        step();
        step();
        chk("rst_rf_we", 32'(bus.rf_we), 32'd0);
        chk("rst_rf_waddr", 32'(bus.rf_waddr), 32'd0);
        chk("rst_rf_wdata", bus.rf_wdata, 32'd0);
        chk("rst_src_onehot", 32'(bus.src_onehot), 32'd0);
        chk("rst_load_timeout", 32'(bus.load_timeout), 32'd0);
`ifdef WB_ILLEGAL_TRAP_EN
        chk("rst_illegal_sel", 32'(bus.illegal_sel), 32'd0);
`endif
        rst = 1'b0;
        step();
        chk("in_ready_after_rst", 32'(bus.in_ready), 32'd1);

        // Back-to-back non-load writebacks
        for (int i = 0; i < 6; i++) begin
            bus.in_valid  = 1'b1;
            bus.wb_sel    = v_sel[i];
            bus.rd        = v_rd[i];
            bus.reg_write = v_rw[i];
            if (v_we[i])
                push(3'b100, v_rd[i], v_dat[i], v_oh[i], cyc + 1);
            step();
            chk($sformatf("onehot_vec%0d", i), 32'(bus.src_onehot), 32'(v_oh[i]));
        end
        bus.in_valid = 1'b0;
        step();

        // Load with data returned in the same cycle
        bus.in_valid   = 1'b1;
        bus.wb_sel     = 3'b001;
        bus.rd         = 5'd7;
        bus.reg_write  = 1'b1;
        bus.load_valid = 1'b1;
        bus.load_data  = 32'h0000_CAFE;
        push(3'b100, 5'd7, 32'h0000_CAFE, 5'b00010, cyc + 1);
        step();
        bus.in_valid   = 1'b0;
        bus.load_valid = 1'b0;
        chk("fast_load_in_ready", 32'(bus.in_ready), 32'd1);
        step();

        // Late load: 3-cycle stall, competing request must not be taken
        bus.in_valid  = 1'b1;
        bus.wb_sel    = 3'b001;
        bus.rd        = 5'd9;
        step();
        bus.wb_sel    = 3'b000;
        bus.rd        = 5'd3;
        bus.alu_result = 32'h0000_0BAD;
        chk("stall_in_ready_1", 32'(bus.in_ready), 32'd0);
        step();
        chk("stall_in_ready_2", 32'(bus.in_ready), 32'd0);
        step();
        chk("stall_in_ready_3", 32'(bus.in_ready), 32'd0);
        bus.load_valid = 1'b1;
        bus.load_data  = 32'h0000_BEEF;
        push(3'b100, 5'd9, 32'h0000_BEEF, 5'b00010, cyc + 1);
        step();
        bus.in_valid   = 1'b0;
        bus.load_valid = 1'b0;
        bus.alu_result = 32'h0000_1234;
        chk("late_load_in_ready", 32'(bus.in_ready), 32'd1);
        chk("late_load_onehot", 32'(bus.src_onehot), 32'b00010);
        step();

        // Load that never returns: timeout after LT wait cycles
        bus.in_valid = 1'b1;
        bus.wb_sel   = 3'b001;
        bus.rd       = 5'd10;
        push(3'b010, 5'd0, 32'd0, 5'b00010, cyc + LT + 1);
        step();
        bus.in_valid = 1'b0;
        for (int i = 0; i < LT; i++) step();
        chk("timeout_in_ready", 32'(bus.in_ready), 32'd1);
        chk("timeout_pulse", 32'(bus.load_timeout), 32'd1);
        // Stray load_valid in IDLE is ignored
        bus.load_valid = 1'b1;
        bus.load_data  = 32'h0000_DEAD;
        step();
        bus.load_valid = 1'b0;
        chk("stray_load_no_we", 32'(bus.rf_we), 32'd0);
        chk("timeout_single_pulse", 32'(bus.load_timeout), 32'd0);
        step();

        // Illegal select code 110
        bus.in_valid   = 1'b1;
        bus.wb_sel     = 3'b110;
        bus.rd         = 5'd14;
        bus.reg_write  = 1'b1;
        bus.alu_result = 32'h0000_7777;
`ifdef WB_ILLEGAL_TRAP_EN
        push(3'b001, 5'd14, 32'd0, 5'b00000, cyc + 1);
`else
        push(3'b100, 5'd14, 32'h0000_7777, 5'b00001, cyc + 1);
`endif
        step();
        bus.in_valid = 1'b0;
        step();

        // Reset in the middle of a load wait
        bus.in_valid = 1'b1;
        bus.wb_sel   = 3'b001;
        bus.rd       = 5'd15;
        step();
        bus.in_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        chk("midrst_rf_we", 32'(bus.rf_we), 32'd0);
        chk("midrst_rf_waddr", 32'(bus.rf_waddr), 32'd0);
        chk("midrst_rf_wdata", bus.rf_wdata, 32'd0);
        chk("midrst_onehot", 32'(bus.src_onehot), 32'd0);
        chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        rst = 1'b0;
        for (int i = 0; i < LT + 3; i++) step();

        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
